cache_control_nway: RTL and testbench
=====================================

Name: cache_control_nway

Overview:
- Parametrised successor cache controller FSM for an N-way set-associative, write-back, write-allocate cache.
- Sits between the CPU memory port, the cache datapath (tag/valid/dirty/data arrays, PLRU) and the line-wide RAM port.
- Adds two things over the 2-way controller:
  - Victim choice: lowest-index invalid way first, else the PLRU way.
  - Full-cache flush: walks every set/way and writes back dirty lines.

Parameters:
- s_index, 3, set index width; num_sets = 2**s_index.
- num_ways, 4, associativity; power of 2, >= 2.
- width, $clog2(num_ways), way-select width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- flush_req  in  1  flush request, held until flush_done.
- hit  in  1  tag match in some valid way.
- hit_way  in  width  matching way.
- valid_out  in  num_ways  valid bits of the selected set.
- dirty_out  in  num_ways  dirty bits of the selected set.
- plru_way  in  width  PLRU victim of the selected set.
- ram_resp_o  in  1  RAM transfer complete.
- mem_resp  out  1  CPU response.
- load  out  1  array write strobe.
- write_data_sel  out  write_data_sel_t  CPU_DATA / RAM_DATA.
- write_en_sel  out  write_en_sel_t  CPU_EN / ALL_EN / NONE_EN (metadata only).
- valid  out  1  valid bit to write.
- dirty  out  1  dirty bit to write.
- lru_load  out  1  PLRU update.
- way_sel  out  width  way for load / writeback read.
- ram_addr_sel  out  ram_addr_sel_t  CPU_ADDR / TAG_ADDR.
- index_sel  out  1  0 = CPU index, 1 = flush_index.
- flush_index  out  s_index  flush set counter.
- ram_read_i  out  1  RAM read.
- ram_write_i  out  1  RAM write.
- flush_done  out  1  flush complete pulse.

Behaviour:
- Reset: state=IDLE, victim_q=0, flush_set=0, flush_way=0. All outputs 0 / enum 0. Takes effect asynchronously, including mid-transfer; RAM strobes drop immediately.
- Arrays read combinationally on the selected index; status is valid in the same cycle.
- Default outputs are 0 in every state unless listed below.
- IDLE:
  - flush_req -> FLUSH_SCAN (priority over CPU requests).
  - else mem_read|mem_write -> LOOKUP.
- LOOKUP:
  - Hit: mem_resp=1, lru_load=1, way_sel=hit_way. On write also load=1, CPU_DATA, CPU_EN, valid=1, dirty=1. Next state IDLE.
  - Miss: victim = lowest i with !valid_out[i], else plru_way; victim_q <= victim.
  - If valid_out[victim] & dirty_out[victim] -> WRITEBACK, else -> FETCH.
- WRITEBACK: way_sel=victim_q, ram_addr_sel=TAG_ADDR, ram_write_i=1. ram_resp_o -> FETCH.
- FETCH: way_sel=victim_q, ram_read_i=1. On the ram_resp_o cycle only: load=1, RAM_DATA, ALL_EN, valid=1, dirty=0; next state RESPOND.
- RESPOND: mem_resp=1, lru_load=1, way_sel=victim_q. On write also load=1, CPU_DATA, CPU_EN, valid=1, dirty=1. Next state IDLE.
- FLUSH_SCAN:
  - index_sel=1, way_sel=flush_way.
  - If valid_out[flush_way] & dirty_out[flush_way] -> FLUSH_WB.
  - Else if last (flush_set=num_sets-1 and flush_way=num_ways-1) -> FLUSH_DONE.
  - Else advance: way increments first; on wrap to 0, set increments.
- FLUSH_WB:
  - index_sel=1, way_sel=flush_way, ram_addr_sel=TAG_ADDR, ram_write_i=1.
  - On ram_resp_o: load=1, NONE_EN, valid=1, dirty=0; then advance, or go to FLUSH_DONE if last.
- FLUSH_DONE: flush_done=1 for one cycle; counters cleared to 0; next state IDLE.
- CPU requests raised during a flush wait in IDLE and are served after flush_done.
- A flush does not modify PLRU.
- mem_read and mem_write both high is illegal; the write path is taken.
- Illegal state encoding: next state and all outputs are X.

Optional Feature:
- Macro CACHE_PERF_COUNT_EN adds 32-bit output ports req_count, hit_count, wb_count.
  - req_count: +1 on IDLE->LOOKUP.
  - hit_count: +1 on a LOOKUP hit.
  - wb_count: +1 on each ram_resp_o in WRITEBACK or FLUSH_WB.
  - All three reset to 0 and wrap at 2^32.
- Without the macro, these ports and their counters do not exist.

Test Plan:
- Read hit in way 2 -> LOOKUP cycle has mem_resp=1, way_sel=2, lru_load=1, load=0; back to IDLE after 2 cycles.
- Read miss, valid_out=4'b1011, plru_way=0 -> victim 2, no writeback; FETCH load only on the ram_resp_o cycle, then RESPOND with mem_resp=1, way_sel=2.
- Write miss, valid_out=4'b1111, dirty_out=4'b0010, plru_way=1 -> WRITEBACK (TAG_ADDR, ram_write_i) -> FETCH -> RESPOND with load=1, CPU_EN, dirty=1.
- Flush with only set 5 way 3 dirty -> exactly one ram_write_i burst with flush_index=5, way_sel=3, then NONE_EN clear; flush_done pulses once after 32 scanned entries.
- Reset asserted mid-FETCH -> ram_read_i=0 at once; IDLE after release; fresh read request then served correctly.
- Flush and mem_read raised together -> flush completes first, then LOOKUP; with CACHE_PERF_COUNT_EN, req_count=1 and wb_count equals the number of dirty lines.

Source files
------------

// File: rtl/cache_control_nway_if.sv
// Shared select encodings and the controller <-> datapath/RAM/CPU bundle.
// master = controller side, slave = CPU/datapath/RAM side.
package cache_control_nway_pkg;
  typedef enum logic {CPU_DATA = 1'b0, RAM_DATA = 1'b1} write_data_sel_t;
  typedef enum logic [1:0] {CPU_EN = 2'd0, ALL_EN = 2'd1, NONE_EN = 2'd2} write_en_sel_t;
  typedef enum logic {CPU_ADDR = 1'b0, TAG_ADDR = 1'b1} ram_addr_sel_t;
endpackage

interface cache_control_nway_if
  import cache_control_nway_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int width    = $clog2(num_ways)
);
  logic                mem_read, mem_write, flush_req;
  logic                hit;
  logic [width-1:0]    hit_way;
  logic [num_ways-1:0] valid_out, dirty_out;
  logic [width-1:0]    plru_way;
  logic                ram_resp_o;

  logic                mem_resp, load;
  write_data_sel_t     write_data_sel;
  write_en_sel_t       write_en_sel;
  logic                valid, dirty, lru_load;
  logic [width-1:0]    way_sel;
  ram_addr_sel_t       ram_addr_sel;
  logic                index_sel;
  logic [s_index-1:0]  flush_index;
  logic                ram_read_i, ram_write_i, flush_done;

  modport master (
    input  mem_read, mem_write, flush_req, hit, hit_way, valid_out, dirty_out,
           plru_way, ram_resp_o,
    output mem_resp, load, write_data_sel, write_en_sel, valid, dirty, lru_load,
           way_sel, ram_addr_sel, index_sel, flush_index, ram_read_i, ram_write_i,
           flush_done
  );

  modport slave (
    output mem_read, mem_write, flush_req, hit, hit_way, valid_out, dirty_out,
           plru_way, ram_resp_o,
    input  mem_resp, load, write_data_sel, write_en_sel, valid, dirty, lru_load,
           way_sel, ram_addr_sel, index_sel, flush_index, ram_read_i, ram_write_i,
           flush_done
  );
endinterface

// File: rtl/cache_control_nway.sv
// N-way write-back/write-allocate cache controller FSM with full-cache flush.
// Optional CACHE_PERF_COUNT_EN adds req_count/hit_count/wb_count outputs.
module cache_control_nway
  import cache_control_nway_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int width    = $clog2(num_ways)
) (
  input  logic clk,
  input  logic rst_n,
  cache_control_nway_if.master bus
`ifdef CACHE_PERF_COUNT_EN
  ,
  output logic [31:0] req_count,
  output logic [31:0] hit_count,
  output logic [31:0] wb_count
`endif
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOOKUP     = 3'd1;
  localparam logic [2:0] WRITEBACK  = 3'd2;
  localparam logic [2:0] FETCH      = 3'd3;
  localparam logic [2:0] RESPOND    = 3'd4;
  localparam logic [2:0] FLUSH_SCAN = 3'd5;
  localparam logic [2:0] FLUSH_WB   = 3'd6;
  localparam logic [2:0] FLUSH_DONE = 3'd7;

  logic [2:0] state, state_n;
  logic [width-1:0] victim, victim_q;
  logic victim_ld, flush_adv, flush_clr;

  // {set, way} as one counter: way advances first and carries into set.
  logic [s_index+width-1:0] flush_cnt;
  logic [width-1:0]         flush_way;
  logic                     flush_last;

  assign flush_way       = flush_cnt[width-1:0];
  assign bus.flush_index = flush_cnt[s_index+width-1:width];
  assign flush_last      = &flush_cnt;

  // Lowest-index invalid way wins; otherwise fall back to PLRU.
  always_comb begin
    victim = bus.plru_way;
    for (int i = num_ways-1; i >= 0; i--)
      if (!bus.valid_out[i]) victim = width'(i);
  end

  always_comb begin
    state_n            = state;
    victim_ld          = 1'b0;
    flush_adv          = 1'b0;
    flush_clr          = 1'b0;
    bus.mem_resp       = 1'b0;
    bus.load           = 1'b0;
    bus.write_data_sel = CPU_DATA;
    bus.write_en_sel   = CPU_EN;
    bus.valid          = 1'b0;
    bus.dirty          = 1'b0;
    bus.lru_load       = 1'b0;
    bus.way_sel        = '0;
    bus.ram_addr_sel   = CPU_ADDR;
    bus.index_sel      = 1'b0;
    bus.ram_read_i     = 1'b0;
    bus.ram_write_i    = 1'b0;
    bus.flush_done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flush_req)                    state_n = FLUSH_SCAN;
        else if (bus.mem_read || bus.mem_write) state_n = LOOKUP;
      end
      LOOKUP: begin
        if (bus.hit) begin
          bus.mem_resp = 1'b1;
          bus.lru_load = 1'b1;
          bus.way_sel  = bus.hit_way;
          if (bus.mem_write) begin
            bus.load  = 1'b1;
            bus.valid = 1'b1;
            bus.dirty = 1'b1;
          end
          state_n = IDLE;
        end else begin
          victim_ld = 1'b1;
          state_n   = (bus.valid_out[victim] && bus.dirty_out[victim]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        bus.way_sel      = victim_q;
        bus.ram_addr_sel = TAG_ADDR;
        bus.ram_write_i  = 1'b1;
        if (bus.ram_resp_o) state_n = FETCH;
      end
      FETCH: begin
        bus.way_sel    = victim_q;
        bus.ram_read_i = 1'b1;
        if (bus.ram_resp_o) begin
          bus.load           = 1'b1;
          bus.write_data_sel = RAM_DATA;
          bus.write_en_sel   = ALL_EN;
          bus.valid          = 1'b1;
          state_n            = RESPOND;
        end
      end
      RESPOND: begin
        bus.mem_resp = 1'b1;
        bus.lru_load = 1'b1;
        bus.way_sel  = victim_q;
        if (bus.mem_write) begin
          bus.load  = 1'b1;
          bus.valid = 1'b1;
          bus.dirty = 1'b1;
        end
        state_n = IDLE;
      end
      FLUSH_SCAN: begin
        bus.index_sel = 1'b1;
        bus.way_sel   = flush_way;
        if (bus.valid_out[flush_way] && bus.dirty_out[flush_way]) state_n = FLUSH_WB;
        else if (flush_last)                                      state_n = FLUSH_DONE;
        else                                                      flush_adv = 1'b1;
      end
      FLUSH_WB: begin
        bus.index_sel    = 1'b1;
        bus.way_sel      = flush_way;
        bus.ram_addr_sel = TAG_ADDR;
        bus.ram_write_i  = 1'b1;
        if (bus.ram_resp_o) begin
          // Metadata-only write: keep the line valid, mark it clean.
          bus.load         = 1'b1;
          bus.write_en_sel = NONE_EN;
          bus.valid        = 1'b1;
          if (flush_last) state_n = FLUSH_DONE;
          else begin
            flush_adv = 1'b1;
            state_n   = FLUSH_SCAN;
          end
        end
      end
      FLUSH_DONE: begin
        bus.flush_done = 1'b1;
        flush_clr      = 1'b1;
        state_n        = IDLE;
      end
      default: begin
        state_n            = 'x;
        victim_ld          = 1'bx;
        flush_adv          = 1'bx;
        flush_clr          = 1'bx;
        bus.mem_resp       = 1'bx;
        bus.load           = 1'bx;
        bus.write_data_sel = write_data_sel_t'(1'bx);
        bus.write_en_sel   = write_en_sel_t'(2'bxx);
        bus.valid          = 1'bx;
        bus.dirty          = 1'bx;
        bus.lru_load       = 1'bx;
        bus.way_sel        = 'x;
        bus.ram_addr_sel   = ram_addr_sel_t'(1'bx);
        bus.index_sel      = 1'bx;
        bus.ram_read_i     = 1'bx;
        bus.ram_write_i    = 1'bx;
        bus.flush_done     = 1'bx;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      victim_q  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      if (victim_ld) victim_q <= victim;
      if (flush_clr)      flush_cnt <= '0;
      else if (flush_adv) flush_cnt <= flush_cnt + 1'b1;
    end
  end

`ifdef CACHE_PERF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_count <= '0;
      hit_count <= '0;
      wb_count  <= '0;
    end else begin
      if (state == IDLE && !bus.flush_req && (bus.mem_read || bus.mem_write))
        req_count <= req_count + 1'b1;
      if (state == LOOKUP && bus.hit)
        hit_count <= hit_count + 1'b1;
      if ((state == WRITEBACK || state == FLUSH_WB) && bus.ram_resp_o)
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: table of CPU requests with a response scoreboard,
// a behavioural line RAM, a per-set metadata model for flushes, and reset/flush sequences.
module tb_cache_control_nway;
  import cache_control_nway_pkg::*;

  localparam int RAM_LAT = 3;

  typedef struct {
    bit rd; bit wr; bit hit; logic [1:0] hway;
    logic [3:0] vo; logic [3:0] dv; logic [1:0] plru;
    logic [1:0] e_way; bit e_load; bit e_dirty; int e_wb; int e_lat;
  } vec_t;

  typedef struct { logic [1:0] way; bit load; bit dirty; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_control_nway_if #(.s_index(3), .num_ways(4)) bus();

`ifdef CACHE_PERF_COUNT_EN
  logic [31:0] req_count, hit_count, wb_count;
`endif

  cache_control_nway #(.s_index(3), .num_ways(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef CACHE_PERF_COUNT_EN
    , .req_count(req_count), .hit_count(hit_count), .wb_count(wb_count)
`endif
  );

  logic [3:0] cv, cd;
  logic [3:0] fv [8];
  logic [3:0] fd [8];
  int n_pass = 0, n_chk = 0;
  int exp_req = 0, exp_hit = 0, exp_wb = 0;
  int ram_cnt = 0;
  exp_t sb[$];
  vec_t vecs[9];

  // Metadata arrays read combinationally on whichever index is selected.
  always_comb begin
    if (bus.index_sel) begin
      bus.valid_out = fv[bus.flush_index];
      bus.dirty_out = fd[bus.flush_index];
    end else begin
      bus.valid_out = cv;
      bus.dirty_out = cd;
    end
  end

  // Line RAM: completes a transfer after RAM_LAT strobe cycles, one-cycle response.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cnt = 0;
      bus.ram_resp_o = 1'b0;
    end else if (bus.ram_resp_o) bus.ram_resp_o = 1'b0;
    else if (bus.ram_read_i || bus.ram_write_i) begin
      ram_cnt++;
      if (ram_cnt == RAM_LAT) begin
        bus.ram_resp_o = 1'b1;
        ram_cnt = 0;
      end
    end else ram_cnt = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    int lat = 0, wb = 0, fl = 0, fetch_bad = 0;
    bit done = 0, prev_wr = 0;
    cv = v.vo; cd = v.dv;
    bus.hit = v.hit; bus.hit_way = v.hway; bus.plru_way = v.plru;
    bus.mem_read = v.rd; bus.mem_write = v.wr;
    e.way = v.e_way; e.load = v.e_load; e.dirty = v.e_dirty;
    sb.push_back(e);
    exp_req++; exp_hit += int'(v.hit); exp_wb += v.e_wb;
    while (!done && lat < 60) begin
      @(negedge clk); #1; lat++;
      if (bus.ram_write_i && !prev_wr) begin
        wb++;
        chk("wb_addr_sel", 32'(bus.ram_addr_sel), 32'(TAG_ADDR));
        chk("wb_way", 32'(bus.way_sel), 32'(v.e_way));
      end
      prev_wr = bus.ram_write_i;
      if (bus.ram_read_i) begin
        if (bus.ram_resp_o) begin
          fl++;
          chk("fetch_load", 32'(bus.load), 1);
          chk("fetch_data_sel", 32'(bus.write_data_sel), 32'(RAM_DATA));
          chk("fetch_en_sel", 32'(bus.write_en_sel), 32'(ALL_EN));
          chk("fetch_valid_dirty", {30'd0, bus.valid, bus.dirty}, 32'b10);
          chk("fetch_way", 32'(bus.way_sel), 32'(v.e_way));
        end else if (bus.load) fetch_bad++;
      end
      if (bus.mem_resp) begin
        done = 1;
        got = sb.pop_front();
        chk("resp_way", 32'(bus.way_sel), 32'(got.way));
        chk("resp_load", 32'(bus.load), 32'(got.load));
        chk("resp_dirty", 32'(bus.dirty), 32'(got.dirty));
        chk("resp_lru_load", 32'(bus.lru_load), 1);
        if (got.load) chk("resp_en_sel", 32'(bus.write_en_sel), 32'(CPU_EN));
      end
    end
    chk("latency", lat, v.e_lat);
    chk("wb_bursts", wb, v.e_wb);
    chk("fetch_count", fl, v.hit ? 0 : 1);
    chk("fetch_early_load", fetch_bad, 0);
    @(posedge clk); #1;
    bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0;
    @(negedge clk); #1;
    chk("idle_after_resp", {30'd0, bus.mem_resp, bus.ram_read_i}, 0);
  endtask

  task automatic flush_run(input bit with_rd, input int exp_bursts,
                           output int b_idx, output int b_way);
    int cyc = 0, scans = 0, bursts = 0, dones = 0, bad = 0, after = -1, resp_at = -1;
    bit prev = 0;
    b_idx = -1; b_way = -1;
    bus.flush_req = 1;
    if (with_rd) begin
      cv = 4'hf; cd = 4'h0; bus.hit = 1; bus.hit_way = 2'd0; bus.mem_read = 1;
      exp_req++; exp_hit++;
    end
    exp_wb += exp_bursts;
    while (cyc < 400) begin
      @(negedge clk); #1; cyc++;
      if (after >= 0) after++;
      if (bus.index_sel && !bus.ram_write_i) scans++;
      if (bus.ram_write_i && !prev) begin
        bursts++;
        b_idx = int'(bus.flush_index); b_way = int'(bus.way_sel);
        chk("flush_target_dirty", 32'(fd[bus.flush_index][bus.way_sel]), 1);
        chk("flush_addr_sel", 32'(bus.ram_addr_sel), 32'(TAG_ADDR));
      end
      prev = bus.ram_write_i;
      if (bus.ram_write_i && bus.ram_resp_o) begin
        chk("flush_clr_load", 32'(bus.load), 1);
        chk("flush_clr_en", 32'(bus.write_en_sel), 32'(NONE_EN));
        chk("flush_clr_vd", {30'd0, bus.valid, bus.dirty}, 32'b10);
        fd[bus.flush_index][bus.way_sel] = 1'b0;
      end
      if (bus.lru_load && after < 0) bad++;
      if (bus.mem_resp) begin
        if (after < 0) bad++;
        else resp_at = after;
      end
      if (bus.flush_done) begin
        dones++;
        if (after < 0) after = 0;
        bus.flush_req = 0;
      end
      if (bus.mem_resp && bus.mem_read) begin
        @(posedge clk); #1;
        bus.mem_read = 0; bus.hit = 0;
      end
      if (after >= 3) break;
    end
    chk("flush_scans", scans, 32);
    chk("flush_bursts", bursts, exp_bursts);
    chk("flush_done_pulses", dones, 1);
    chk("flush_side_effects", bad, 0);
    chk("flush_index_cleared", 32'(bus.flush_index), 0);
    if (with_rd) chk("read_after_flush", resp_at, 2);
  endtask

  task automatic check_perf();
`ifdef CACHE_PERF_COUNT_EN
    chk("req_count", req_count, exp_req);
    chk("hit_count", hit_count, exp_hit);
    chk("wb_count", wb_count, exp_wb);
`endif
  endtask

  initial begin
    int bi, bw, k;
    vecs[0] = '{1'b1,1'b0,1'b1,2'd2,4'b1111,4'b0000,2'd0, 2'd2,1'b0,1'b0,0,1};
    vecs[1] = '{1'b0,1'b1,1'b1,2'd1,4'b1111,4'b0000,2'd0, 2'd1,1'b1,1'b1,0,1};
    vecs[2] = '{1'b1,1'b0,1'b0,2'd0,4'b1011,4'b0000,2'd0, 2'd2,1'b0,1'b0,0,5};
    vecs[3] = '{1'b0,1'b1,1'b0,2'd0,4'b1111,4'b0010,2'd1, 2'd1,1'b1,1'b1,1,9};
    vecs[4] = '{1'b1,1'b0,1'b0,2'd0,4'b1111,4'b0000,2'd3, 2'd3,1'b0,1'b0,0,5};
    vecs[5] = '{1'b1,1'b0,1'b0,2'd0,4'b0000,4'b1111,2'd2, 2'd0,1'b0,1'b0,0,5};
    vecs[6] = '{1'b1,1'b1,1'b1,2'd3,4'b1111,4'b1111,2'd0, 2'd3,1'b1,1'b1,0,1};
    vecs[7] = '{1'b1,1'b0,1'b0,2'd0,4'b1111,4'b1111,2'd0, 2'd0,1'b0,1'b0,1,9};
    vecs[8] = '{1'b0,1'b1,1'b0,2'd0,4'b0111,4'b1000,2'd1, 2'd3,1'b1,1'b1,0,5};

    rst_n = 0;
    bus.mem_read = 0; bus.mem_write = 0; bus.flush_req = 0; bus.hit = 0;
    bus.hit_way = 0; bus.plru_way = 0; cv = 0; cd = 0;
    for (int s = 0; s < 8; s++) begin fv[s] = 4'hf; fd[s] = 4'h0; end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_load", {30'd0, bus.mem_resp, bus.load}, 0);
    chk("rst_ram_strobes", {30'd0, bus.ram_read_i, bus.ram_write_i}, 0);
    chk("rst_flush_index", 32'(bus.flush_index), 0);
    chk("rst_way_sel", 32'(bus.way_sel), 0);
    chk("rst_misc", {28'd0, bus.index_sel, bus.flush_done, bus.lru_load, bus.valid}, 0);
    rst_n = 1;
    @(negedge clk); #1;
    check_perf();

    foreach (vecs[i]) run_vec(vecs[i]);
    check_perf();

    // Reset in the middle of a line fetch.
    cv = 4'b1011; cd = 4'b0000; bus.plru_way = 0; bus.hit = 0; bus.mem_read = 1;
    k = 0;
    while (!bus.ram_read_i && k < 20) begin @(negedge clk); #1; k++; end
    chk("reached_fetch", 32'(bus.ram_read_i), 1);
    rst_n = 0;
    #1;
    chk("rst_mid_fetch_read", 32'(bus.ram_read_i), 0);
    chk("rst_mid_fetch_load", {30'd0, bus.load, bus.mem_resp}, 0);
    bus.mem_read = 0;
    exp_req = 0; exp_hit = 0; exp_wb = 0;
    repeat (2) @(negedge clk);
    #1; rst_n = 1;
    @(negedge clk); #1;
    chk("post_rst_idle", {29'd0, bus.ram_read_i, bus.mem_resp, bus.index_sel}, 0);
    run_vec(vecs[2]);

    // Flush with one dirty line, read request raised together with it.
    fd[5][3] = 1'b1;
    flush_run(1'b1, 1, bi, bw);
    chk("flush1_index", bi, 5);
    chk("flush1_way", bw, 3);
    check_perf();

    // Several dirty lines incl. the very last entry; an invalid dirty line is skipped.
    fd[0][0] = 1'b1; fd[3][1] = 1'b1; fd[7][3] = 1'b1;
    fv[2] = 4'b1011; fd[2] = 4'b0100;
    flush_run(1'b0, 3, bi, bw);
    chk("flush2_last_index", bi, 7);
    chk("flush2_last_way", bw, 3);
    flush_run(1'b0, 0, bi, bw);
    check_perf();

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
